// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port arbiter (fetch, loader) in front of a single-port,
// synchronous-read instruction memory. Grants and the memory strobe are
// combinational in the request cycle. Valid, error and read data follow one
// cycle later.
// Optional feature: define IMEM_ARB_RR_EN to alternate simultaneous unlocked
// requests with a last-granted pointer. When it is undefined, fetch wins.
module imem_arbiter #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_valid,
    output logic              l_err,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT_F, GRANT_L, LOCKED_L} state_t;

    // One past the last mapped byte. It is held in 33 bits so that a BASE
    // near the top of the address space cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << ADDR_W);

    state_t state_reg;
`ifdef IMEM_ARB_RR_EN
    logic   ptr_reg;            // 1: loader wins the next tie
`endif

    logic              f_win, l_win, f_ok, l_ok;
    logic [ADDR_W-1:0] f_idx, l_idx;
    logic              f_valid_reg, f_err_reg, f_rd_reg;
    logic              l_valid_reg, l_err_reg, l_rd_reg;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return ADDR_W'(off >> 2);
    endfunction

    assign f_ok  = addr_ok(f_addr);
    assign l_ok  = addr_ok(l_addr);
    assign f_idx = word_idx(f_addr);
    assign l_idx = word_idx(l_addr);

    // Pick the winner for this cycle. Reset low suppresses all grants at once.
    always_comb begin
        f_win = 1'b0;
        l_win = 1'b0;
        if (reset) begin
            if (state_reg == LOCKED_L) begin
                l_win = l_req;
            end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
                if (ptr_reg) l_win = 1'b1;
                else         f_win = 1'b1;
`else
                f_win = 1'b1;
`endif
            end else begin
                f_win = f_req;
                l_win = l_req;
            end
        end
    end

    assign f_gnt     = f_win;
    assign l_gnt     = l_win;
    assign mem_en    = (f_win & f_ok) | (l_win & l_ok);
    assign mem_we    = l_win & l_ok & l_we;
    assign mem_addr  = (f_win & f_ok) ? f_idx : ((l_win & l_ok) ? l_idx : '0);
    assign mem_wdata = mem_we ? l_wdata : 32'h0;

    // Ownership FSM. A locked loader grant keeps ownership. The lock is
    // released on the first cycle in LOCKED_L that sees l_lock low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
`ifdef IMEM_ARB_RR_EN
            ptr_reg   <= 1'b0;
`endif
        end else begin
            if (l_win && l_lock) state_reg <= LOCKED_L;
            else if (l_win)      state_reg <= GRANT_L;
            else if (f_win)      state_reg <= GRANT_F;
            else                 state_reg <= IDLE;
`ifdef IMEM_ARB_RR_EN
            if (l_win)      ptr_reg <= 1'b0;
            else if (f_win) ptr_reg <= 1'b1;
`endif
        end
    end

    // Response pipeline, one cycle behind the grant. The _rd flags select
    // memory data only for in-range reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_valid_reg <= 1'b0;
            f_err_reg   <= 1'b0;
            f_rd_reg    <= 1'b0;
            l_valid_reg <= 1'b0;
            l_err_reg   <= 1'b0;
            l_rd_reg    <= 1'b0;
        end else begin
            f_valid_reg <= f_win;
            f_err_reg   <= f_win & ~f_ok;
            f_rd_reg    <= f_win & f_ok;
            l_valid_reg <= l_win;
            l_err_reg   <= l_win & ~l_ok;
            l_rd_reg    <= l_win & l_ok & ~l_we;
        end
    end

    assign f_valid = f_valid_reg;
    assign f_err   = f_err_reg;
    assign f_rdata = f_rd_reg ? mem_rdata : 32'h0;
    assign l_valid = l_valid_reg;
    assign l_err   = l_err_reg;
    assign l_rdata = l_rd_reg ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vector table plus hand-written sequences for
// contention, burst lock and asynchronous reset. The memory behind the
// arbiter is a synchronous-read model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_valid, f_err, l_gnt, l_valid, l_err;
    logic [31:0] f_rdata, l_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;

    logic [31:0] mem_model [1024];

    int n_vec = 0;
    int n_err = 0;

    imem_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_valid(l_valid), .l_err(l_err),
        .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            mem_rdata <= mem_model[mem_addr];
        end
    end

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        l_lock;
        logic        e_fg;
        logic        e_lg;
        logic        e_en;
        logic        e_we;
        logic [9:0]  e_ma;
        logic        e_fv;
        logic        e_fe;
        logic [31:0] e_fd;
        logic        e_lv;
        logic        e_le;
        logic [31:0] e_ld;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                         input logic lw, input logic [31:0] la, input logic [31:0] ld,
                         input logic lk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw;
        l_addr = la; l_wdata = ld; l_lock = lk;
    endtask

    task automatic chk_gnt(input string tag, input logic ef, input logic el);
        chk({tag, ".f_gnt"}, {31'b0, f_gnt}, {31'b0, ef});
        chk({tag, ".l_gnt"}, {31'b0, l_gnt}, {31'b0, el});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hA000_0000 | i;
        mem_model[1] = 32'h2402_0001;

        //           f_req  f_addr        l_req  l_we   l_addr        l_wdata       lock   fg     lg     en     we     ma      fv     fe     fd            lv     le     ld
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_3004, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    1'b1, 1'b0, 32'h2402_0001, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_3008, 32'hDEAD_BEEF,1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd2,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd2,    1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,    1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,    1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_3FFC, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1023, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_3FFC, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1023, 1'b1, 1'b0, 32'hA000_03FF, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_3010, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd4,    1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA000_03FF};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_3001, 32'h1234_5678,1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA000_0004};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};

        // Reset state. A request raised while reset is held must not be granted.
        reset = 1'b0;
        drive(1'b1, 32'h3004, 1'b1, 1'b1, 32'h3008, 32'h1, 1'b0);
        repeat (2) @(negedge clk);
        chk_gnt("rst", 1'b0, 1'b0);
        chk("rst.mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst.mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst.f_valid", {31'b0, f_valid}, 32'h0);
        chk("rst.l_valid", {31'b0, l_valid}, 32'h0);
        chk("rst.f_rdata", f_rdata, 32'h0);
        $display("reset check done");
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;

        // Table of single-requester vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_we,
                  vecs[i].l_addr, vecs[i].l_wdata, vecs[i].l_lock);
            #2;
            chk($sformatf("v%0d.f_gnt", i),   {31'b0, f_gnt},   {31'b0, vecs[i].e_fg});
            chk($sformatf("v%0d.l_gnt", i),   {31'b0, l_gnt},   {31'b0, vecs[i].e_lg});
            chk($sformatf("v%0d.mem_en", i),  {31'b0, mem_en},  {31'b0, vecs[i].e_en});
            chk($sformatf("v%0d.mem_we", i),  {31'b0, mem_we},  {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d.mem_addr", i),{22'b0, mem_addr},{22'b0, vecs[i].e_ma});
            chk($sformatf("v%0d.f_valid", i), {31'b0, f_valid}, {31'b0, vecs[i].e_fv});
            chk($sformatf("v%0d.f_err", i),   {31'b0, f_err},   {31'b0, vecs[i].e_fe});
            chk($sformatf("v%0d.f_rdata", i), f_rdata,          vecs[i].e_fd);
            chk($sformatf("v%0d.l_valid", i), {31'b0, l_valid}, {31'b0, vecs[i].e_lv});
            chk($sformatf("v%0d.l_err", i),   {31'b0, l_err},   {31'b0, vecs[i].e_le});
            chk($sformatf("v%0d.l_rdata", i), l_rdata,          vecs[i].e_ld);
            $display("vec %0d: f_req=%0b f_addr=%h l_req=%0b l_we=%0b l_addr=%h",
                     i, vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_we, vecs[i].l_addr);
        end

        // Contention. Both ports request for four cycles, then fetch drops out.
        for (int c = 0; c < 5; c++) begin
            logic ef, el;
            @(negedge clk);
            drive(c < 4, 32'h3000, 1'b1, 1'b0, 32'h3004, 32'h0, 1'b0);
            #2;
`ifdef IMEM_ARB_RR_EN
            ef = (c < 4) && (c % 2 == 0);
`else
            ef = (c < 4);
`endif
            el = !ef;
            chk_gnt($sformatf("cont%0d", c), ef, el);
            chk($sformatf("cont%0d.mem_addr", c), {22'b0, mem_addr}, ef ? 32'd0 : 32'd1);
            $display("contention cycle %0d: f_gnt=%0b l_gnt=%0b", c, f_gnt, l_gnt);
        end

        // Burst lock. The loader takes a lock, then holds it for three more
        // cycles against a fetch request. The release cycle grants nothing,
        // and fetch is served on the following cycle.
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk); drive(1'b0, 32'h3000, 1'b1, 1'b0, 32'h3004, 32'h0, 1'b1);
        #2; chk_gnt("lock0", 1'b0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); drive(1'b1, 32'h3000, 1'b1, 1'b0, 32'h3004, 32'h0, 1'b1);
            #2; chk_gnt($sformatf("lock%0d", c), 1'b0, 1'b1);
            $display("lock cycle %0d: f_gnt=%0b l_gnt=%0b", c, f_gnt, l_gnt);
        end
        @(negedge clk); drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2; chk_gnt("unlock", 1'b0, 1'b0);
        @(negedge clk);
        #2; chk_gnt("after_unlock", 1'b1, 1'b0);
        $display("lock release: f_gnt=%0b", f_gnt);

        // Asynchronous reset pulsed during an in-flight grant.
        @(negedge clk); drive(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2; chk_gnt("pre_rst", 1'b1, 1'b0);
        #1; reset = 1'b0;
        #1;
        chk_gnt("in_rst", 1'b0, 1'b0);
        chk("in_rst.mem_en", {31'b0, mem_en}, 32'h0);
        chk("in_rst.f_valid", {31'b0, f_valid}, 32'h0);
        chk("in_rst.f_rdata", f_rdata, 32'h0);
        @(negedge clk); reset = 1'b1; drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2; chk("post_rst.f_valid", {31'b0, f_valid}, 32'h0);
        @(negedge clk); drive(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2; chk_gnt("post_rst_req", 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("post_rst.f_valid2", {31'b0, f_valid}, 32'h1);
        chk("post_rst.f_rdata", f_rdata, 32'h2402_0001);
        $display("reset recovery: f_valid=%0b f_rdata=%h", f_valid, f_rdata);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
